// File: rtl/tb_monitor_pkg.sv
// Shared constants and state encoding for the test-result monitor.
// Holds the default parameter values and the snooped-register shadow indices.
package tb_monitor_pkg;

  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_DONE_REG       = 26;
  localparam int unsigned DEF_PASS_REG       = 27;
  localparam int unsigned DEF_TNUM_REG       = 3;
  localparam int unsigned DEF_DONE_VAL       = 1;
  localparam int unsigned DEF_SETTLE_CYCLES  = 10;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CYC_W      = 32;

  // Shadow register file slots
  localparam int unsigned       SH_NUM   = 3;
  localparam int unsigned       SH_IDX_W = 2;
  localparam logic [SH_IDX_W-1:0] SH_DONE = 2'd0;
  localparam logic [SH_IDX_W-1:0] SH_PASS = 2'd1;
  localparam logic [SH_IDX_W-1:0] SH_TNUM = 2'd2;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SETTLE,
    ST_DONE_PASS,
    ST_DONE_FAIL,
    ST_DONE_TIMEOUT
  } mon_state_t;

  function automatic logic is_done_state(input mon_state_t s);
    return (s == ST_DONE_PASS) || (s == ST_DONE_FAIL) || (s == ST_DONE_TIMEOUT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         i_clr_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/test_result_monitor.sv
// Snoops register-file writebacks to detect test completion, then reports
// pass/fail after a settle window, or timeout if completion never arrives.
module test_result_monitor
  import tb_monitor_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned DONE_REG       = DEF_DONE_REG,
  parameter int unsigned PASS_REG       = DEF_PASS_REG,
  parameter int unsigned TNUM_REG       = DEF_TNUM_REG,
  parameter int unsigned DONE_VAL       = DEF_DONE_VAL,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [DATA_W-1:0]     fail_testnum,
  output logic [CYC_W-1:0]      cycle_count
);

  // A zero-length settle window still samples on the first SETTLE cycle
  localparam int unsigned       SETTLE_LAST  = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
  localparam int unsigned       SETTLE_W     = $clog2(SETTLE_LAST + 2);
  localparam logic [CYC_W-1:0]  TIMEOUT_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

  mon_state_t          r_state;
  mon_state_t          w_state_nxt;
  logic [DATA_W-1:0]   r_shadow [SH_NUM];
  logic                r_done;
  logic                r_pass;
  logic                r_fail;
  logic                r_timeout;

  logic                w_wr_valid;
  logic                w_wr_done_reg;
  logic                w_trigger;
  logic                w_in_settle;
  logic                w_counting;
  logic                w_settle_clr_n;
  logic                w_settle_end;
  logic                w_timeout_hit;
  logic [CYC_W-1:0]    w_cycle_cnt;
  logic [SETTLE_W-1:0] w_settle_cnt;

  assign w_wr_valid     = wb_en && (wb_addr != '0);
  assign w_wr_done_reg  = w_wr_valid && (wb_addr == REG_ADDR_W'(DONE_REG));
  assign w_trigger      = w_wr_done_reg && (wb_data == DATA_W'(DONE_VAL));
  assign w_in_settle    = (r_state == ST_SETTLE);
  assign w_counting     = (r_state == ST_RUN) || w_in_settle;
  assign w_settle_clr_n = rst && w_in_settle;
  assign w_settle_end   = (w_settle_cnt == SETTLE_W'(SETTLE_LAST));
  assign w_timeout_hit  = (TIMEOUT_CYCLES != 0) && (w_cycle_cnt == TIMEOUT_LAST);

  sat_counter #(.W(CYC_W)) u_cycle_cnt (
    .clk     (clk),
    .i_clr_n (rst),
    .i_en    (w_counting),
    .o_count (w_cycle_cnt)
  );

  // Held clear outside SETTLE so each settle window starts from zero
  sat_counter #(.W(SETTLE_W)) u_settle_cnt (
    .clk     (clk),
    .i_clr_n (w_settle_clr_n),
    .i_en    (w_in_settle),
    .o_count (w_settle_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Completion trigger outranks timeout in the same RUN cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_trigger) begin
          w_state_nxt = ST_SETTLE;
        end else if (w_timeout_hit) begin
          w_state_nxt = ST_DONE_TIMEOUT;
        end
      end
      ST_SETTLE: begin
        if (w_settle_end) begin
          w_state_nxt = (r_shadow[SH_PASS] == DATA_W'(1)) ? ST_DONE_PASS : ST_DONE_FAIL;
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // Shadows track writes until a DONE state freezes them
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shadow[SH_DONE] <= '0;
      r_shadow[SH_PASS] <= '0;
      r_shadow[SH_TNUM] <= '0;
    end else if (w_wr_valid && !is_done_state(r_state)) begin
      if (wb_addr == REG_ADDR_W'(DONE_REG)) r_shadow[SH_DONE] <= wb_data;
      if (wb_addr == REG_ADDR_W'(PASS_REG)) r_shadow[SH_PASS] <= wb_data;
      if (wb_addr == REG_ADDR_W'(TNUM_REG)) r_shadow[SH_TNUM] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done    <= is_done_state(w_state_nxt);
      r_pass    <= (w_state_nxt == ST_DONE_PASS);
      r_fail    <= (w_state_nxt == ST_DONE_FAIL);
      r_timeout <= (w_state_nxt == ST_DONE_TIMEOUT);
    end
  end

  assign done         = r_done;
  assign pass         = r_pass;
  assign fail         = r_fail;
  assign timeout      = r_timeout;
  assign fail_testnum = r_shadow[SH_TNUM];
  assign cycle_count  = w_cycle_cnt;

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed bench for test_result_monitor with hand-computed expectations.
module tb_test_result_monitor;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          done;
  logic          pass;
  logic          fail;
  logic          timeout;
  logic [DW-1:0] fail_testnum;
  logic [31:0]   cycle_count;

  int n_vec     = 0;
  int n_miscmp  = 0;

  always #5 clk = ~clk;

  test_result_monitor #(
    .DATA_W         (DW),
    .DONE_REG       (26),
    .PASS_REG       (27),
    .TNUM_REG       (3),
    .DONE_VAL       (1),
    .SETTLE_CYCLES  (10),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .fail_testnum (fail_testnum),
    .cycle_count  (cycle_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [DW-1:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    step();
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    steps(2);
    rst = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic d, input logic p,
                           input logic f, input logic t);
    chk({tag, ".done"},    32'(done),    32'(d));
    chk({tag, ".pass"},    32'(pass),    32'(p));
    chk({tag, ".fail"},    32'(fail),    32'(f));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    rst     = 1'b0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;

    // Reset state
    do_reset();
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.testnum", fail_testnum, 32'd0);
    chk("rst.cycles",  cycle_count,  32'd0);

    // Pass: x27=1 then x26=1, done exactly 11 cycles after the x26 write
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    steps(9);
    chk("pass.early_done", 32'(done), 32'd0);
    step();
    chk_flags("pass", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pass.cycles", cycle_count, 32'd12);
    wr(5'd27, 32'd0);
    wr(5'd3,  32'd9);
    steps(3);
    chk_flags("pass.absorb", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pass.absorb.testnum", fail_testnum, 32'd0);
    chk("pass.absorb.cycles",  cycle_count,  32'd12);

    // Fail: x3=5, x27=0, x26=1
    do_reset();
    wr(5'd3,  32'd5);
    wr(5'd27, 32'd0);
    wr(5'd26, 32'd1);
    steps(10);
    chk_flags("fail", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("fail.testnum", fail_testnum, 32'd5);

    // Late pass-flag write three cycles into the settle window
    do_reset();
    wr(5'd26, 32'd1);
    steps(2);
    wr(5'd27, 32'd1);
    steps(6);
    chk("late.early_done", 32'(done), 32'd0);
    step();
    chk_flags("late", 1'b1, 1'b1, 1'b0, 1'b0);

    // Timeout at cycle_count 50 with no completion write
    do_reset();
    steps(49);
    chk_flags("to.pre", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to.pre.cycles", cycle_count, 32'd49);
    step();
    chk_flags("to", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("to.cycles", cycle_count, 32'd50);
    steps(3);
    chk("to.frozen.cycles", cycle_count, 32'd50);

    // Trigger in the same cycle the timeout would fire: settle wins
    do_reset();
    steps(49);
    wr(5'd26, 32'd1);
    chk_flags("race", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("race.cycles", cycle_count, 32'd50);
    steps(9);
    chk("race.early_done", 32'(done), 32'd0);
    step();
    chk_flags("race.end", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("race.end.cycles", cycle_count, 32'd60);

    // Wrong done value and x0 writes do not leave RUN
    do_reset();
    wr(5'd26, 32'd2);
    wr(5'd0,  32'd1);
    steps(12);
    chk_flags("norun", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("norun.cycles", cycle_count, 32'd14);

    // Reset mid-SETTLE leaves no residual pass flag
    do_reset();
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    steps(4);
    rst = 1'b0;
    step();
    chk_flags("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst.cycles", cycle_count, 32'd0);
    rst = 1'b1;
    wr(5'd26, 32'd1);
    steps(10);
    chk_flags("midrst.after", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("midrst.after.cycles", cycle_count, 32'd11);

    // Reset out of a DONE state, then a clean pass sequence
    rst = 1'b0;
    step();
    chk_flags("donerst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    wr(5'd3,  32'd7);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    steps(10);
    chk_flags("donerst.pass", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("donerst.testnum", fail_testnum, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/test_result_monitor.md
TEST_RESULT_MONITOR -- requirements
Module: test_result_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register/writeback data width.
REQ-002 SHALL have parameter DONE_REG, default 26, register index whose write signals test completion.
REQ-003 SHALL have parameter PASS_REG, default 27, register index holding the pass flag.
REQ-004 SHALL have parameter TNUM_REG, default 3, register index holding the current test number.
REQ-005 SHALL have parameter DONE_VAL, default 1, value at DONE_REG that triggers completion.
REQ-006 SHALL have parameter SETTLE_CYCLES, default 10, cycles between the completion trigger and the pass sample.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 100000, RUN cycles before timeout; 0 disables timeout.
REQ-008 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-010 SHALL have port wb_en, input, 1, register-file write strobe, snooped.
REQ-011 SHALL have port wb_addr, input, 5, register-file write index.
REQ-012 SHALL have port wb_data, input, DATA_W, register-file write data.
REQ-013 SHALL have port done, output, 1, sticky: test finished by pass, fail or timeout.
REQ-014 SHALL have port pass, output, 1, sticky: pass-flag sample equalled 1.
REQ-015 SHALL have port fail, output, 1, sticky: pass-flag sample not equal to 1.
REQ-016 SHALL have port timeout, output, 1, sticky: the RUN-cycle limit was reached.
REQ-017 SHALL have port fail_testnum, output, DATA_W, shadow of TNUM_REG frozen on entering any DONE state.
REQ-018 SHALL have port cycle_count, output, 32, RUN+SETTLE cycles elapsed, saturating at all-ones.

Function
REQ-019 SHALL keep shadow copies of DONE_REG, PASS_REG and TNUM_REG, each updated one cycle after a wb_en write to its index.
REQ-020 SHALL ignore all writes with wb_addr==0.
REQ-021 SHALL implement states RUN, SETTLE, DONE_PASS, DONE_FAIL, DONE_TIMEOUT.
REQ-022 SHALL move RUN->SETTLE in the cycle after the first write of DONE_VAL to DONE_REG.
REQ-023 SHALL not trigger on a DONE_REG write of any other value.
REQ-024 SHALL keep updating shadows during SETTLE, so late PASS_REG writes are observed.
REQ-025 SHALL sample the PASS_REG shadow after exactly SETTLE_CYCLES SETTLE cycles, entering DONE_PASS if it equals 1, else DONE_FAIL.
REQ-026 SHALL sample on the first SETTLE cycle when SETTLE_CYCLES==0.
REQ-027 SHALL move RUN->DONE_TIMEOUT when cycle_count reaches TIMEOUT_CYCLES while still in RUN.
REQ-028 SHALL give the completion trigger priority over timeout when both occur in the same cycle.
REQ-029 SHALL make DONE states absorbing until reset, ignoring further writes and freezing all outputs.
REQ-030 SHALL keep pass, fail and timeout mutually exclusive, with done equal to their OR.

Reset
REQ-031 SHALL, while rst==0 at a clock edge, enter RUN and clear all shadows, cycle_count, done, pass, fail, timeout and fail_testnum to 0.
REQ-032 SHALL abandon a reset asserted mid-SETTLE or in a DONE state with no residual state, restarting monitoring from RUN on the first edge with rst==1.

Structure
REQ-033 SHALL place the state enumeration and default parameter constants in the shared package tb_monitor_pkg.
REQ-034 SHALL instantiate one sub-module, sat_counter (parametrised width, enable, synchronous active-low clear), for cycle_count and the settle counter.

Verification
REQ-035 SHALL cover: write x27=1 then x26=1 -> pass=1, done=1 exactly 11 cycles after the x26 write, fail=0.
REQ-036 SHALL cover: write x3=5, x27=0, then x26=1 -> fail=1, fail_testnum=5, pass=0.
REQ-037 SHALL cover: write x26=1, then x27=1 three cycles later -> pass=1, confirming a write late in the settle window is observed.
REQ-038 SHALL cover: TIMEOUT_CYCLES=50 with no x26 write -> timeout=1 at cycle_count 50; same-cycle trigger instead -> SETTLE entered, no timeout.
REQ-039 SHALL cover: write x26=2, then x0=1 -> state remains RUN.
REQ-040 SHALL cover: rst pulsed low during SETTLE -> all outputs 0, and a subsequent pass sequence is reported correctly.
